sram_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the IF stage (inst master) and the EX/ME stages (data master).
- Picks one master per address phase, forwards its request, and tags each accepted transaction with its master ID in an in-order FIFO.
- Routes each returning data_ok/rdata to the master at the FIFO head.
- Sits between the pipeline's inst/data SRAM interfaces and the SRAM or AXI bridge.

---
 rtl/sram_req_arbiter.sv | 104 ++++++++++
 tb/tb_sram_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-style port between inst and data masters with in-order ID tracking; ARB_RR_EN selects round-robin IDLE arbitration
// Ports: clk_i/reset_i (sync, active-high); inst_*_i / data_*_i master requests with *_addr_ok_o, *_data_ok_o, *_rdata_o responses;
//        mem_*_o shared request, mem_addr_ok_i/mem_data_ok_i/mem_rdata_i slave response; err_spurious_o sticky response-without-request flag.
module sram_req_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                inst_req_i,
  input  logic                inst_wr_i,
  input  logic [1:0]          inst_size_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  input  logic [DATA_W-1:0]   inst_wdata_i,
  input  logic [DATA_W/8-1:0] inst_wstrb_i,
  output logic                inst_addr_ok_o,
  output logic                inst_data_ok_o,
  output logic [DATA_W-1:0]   inst_rdata_o,
  input  logic                data_req_i,
  input  logic                data_wr_i,
  input  logic [1:0]          data_size_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_wstrb_i,
  output logic                data_addr_ok_o,
  output logic                data_data_ok_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_wr_o,
  output logic [1:0]          mem_size_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_addr_ok_i,
  input  logic                mem_data_ok_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                err_spurious_o
);
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;
  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;
  state_e               state_q, state_d;
  logic [MAX_OUTST-1:0] fifo_q;
  logic [PW-1:0]        wp_q, rp_q;
  logic [CW-1:0]        cnt_q;
  logic                 err_q;
  logic                 pick, sel_id, full, empty, accept, pop, head;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction
`ifdef ARB_RR_EN
  logic last_id_q;
  // on a tie the master that did not win the last accept goes first
  assign pick = (inst_req_i & data_req_i) ? ~last_id_q : data_req_i;
  always_ff @(posedge clk_i)
    if (reset_i) last_id_q <= 1'b1;
    else if (accept) last_id_q <= sel_id;
`else
  assign pick = data_req_i;
`endif
  assign full  = cnt_q == CW'(MAX_OUTST);
  assign empty = cnt_q == '0;
  assign head  = fifo_q[rp_q];
  always_ff @(posedge clk_i)
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = (state_q == IDLE) ? ((mem_req_o & ~mem_addr_ok_i) ? (sel_id ? LOCK_D : LOCK_I) : IDLE)
                                : (mem_addr_ok_i ? IDLE : state_q);
  end
  always_comb begin
    sel_id         = (state_q == IDLE) ? pick : (state_q == LOCK_D);
    mem_req_o      = ~reset_i & ~full & (sel_id ? data_req_i : inst_req_i);
    mem_wr_o       = mem_req_o & (sel_id ? data_wr_i : inst_wr_i);
    mem_size_o     = mem_req_o ? (sel_id ? data_size_i : inst_size_i) : '0;
    mem_addr_o     = mem_req_o ? (sel_id ? data_addr_i : inst_addr_i) : '0;
    mem_wdata_o    = mem_req_o ? (sel_id ? data_wdata_i : inst_wdata_i) : '0;
    mem_wstrb_o    = mem_req_o ? (sel_id ? data_wstrb_i : inst_wstrb_i) : '0;
    accept         = mem_req_o & mem_addr_ok_i;
    inst_addr_ok_o = accept & ~sel_id;
    data_addr_ok_o = accept & sel_id;
    pop            = ~reset_i & mem_data_ok_i & ~empty;
    inst_data_ok_o = pop & ~head;
    data_data_ok_o = pop & head;
    inst_rdata_o   = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    err_spurious_o = err_q;
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      fifo_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) fifo_q[wp_q] <= sel_id;
      wp_q  <= accept ? nxt(wp_q) : wp_q;
      rp_q  <= pop ? nxt(rp_q) : rp_q;
      cnt_q <= cnt_q + CW'(accept) - CW'(pop);
      err_q <= err_q | (mem_data_ok_i & empty);
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: scoreboard bench for sram_req_arbiter
module tb_sram_req_arbiter;
  logic        clk = 0, reset = 1;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, err;
  int          checks = 0, errors = 0;
  bit          sb[$];
  bit          w, e;
  always #5 clk = ~clk;
  sram_req_arbiter #(.MAX_OUTST(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .reset_i(reset),
    .inst_req_i(inst_req), .inst_wr_i(inst_wr), .inst_size_i(inst_size), .inst_addr_i(inst_addr),
    .inst_wdata_i(inst_wdata), .inst_wstrb_i(inst_wstrb), .inst_addr_ok_o(inst_addr_ok),
    .inst_data_ok_o(inst_data_ok), .inst_rdata_o(inst_rdata),
    .data_req_i(data_req), .data_wr_i(data_wr), .data_size_i(data_size), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_wstrb_i(data_wstrb), .data_addr_ok_o(data_addr_ok),
    .data_data_ok_o(data_data_ok), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_size_o(mem_size), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_addr_ok_i(mem_addr_ok),
    .mem_data_ok_i(mem_data_ok), .mem_rdata_i(mem_rdata), .err_spurious_o(err)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    {inst_req, inst_wr, inst_size, inst_addr, inst_wdata, inst_wstrb} = '0;
    {data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb} = '0;
    {mem_addr_ok, mem_data_ok, mem_rdata} = '0;
  endtask
  task automatic do_reset;
    cyc();
    reset = 1;
    idle_inputs();
    cyc();
    cyc();
    reset = 0;
    sb.delete();
  endtask
  task automatic pop_exp(output bit id);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: response with no expected transaction");
      id = 0;
    end else id = sb.pop_front();
  endtask
  task automatic test_reset;
    cyc();
    reset = 1;
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1234_5678; mem_addr_ok = 1; mem_data_ok = 1;
    cyc();
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_addr} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b aok=%b%b dok=%b%b addr=%h, expected all 0",
               mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_addr);
    end
    idle_inputs();
    cyc();
    reset = 0;
    cyc();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask
  task automatic test_basic;
    cyc();
    inst_req = 1; inst_wr = 1; inst_size = 2; inst_addr = 32'h1C00_0000;
    inst_wdata = 32'hDEAD_BEEF; inst_wstrb = 4'hF; mem_addr_ok = 1;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== {3'b110, 32'h1C00_0000}) begin
      errors++;
      $display("FAIL basic_accept: got req=%b aok=%b%b addr=%h expected 110 1c000000",
               mem_req, inst_addr_ok, data_addr_ok, mem_addr);
    end
    checks++;
    if ({mem_wr, mem_size, mem_wdata, mem_wstrb} !== {1'b1, 2'd2, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("FAIL basic_payload: got wr=%b size=%0d wdata=%h wstrb=%h expected 1 2 deadbeef f",
               mem_wr, mem_size, mem_wdata, mem_wstrb);
    end
    sb.push_back(0);
    cyc();
    idle_inputs();
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
    #1;
    pop_exp(e);
    checks++;
    if ({inst_data_ok, data_data_ok, inst_rdata} !== {~e, e, 32'h0280_0C0C}) begin
      errors++;
      $display("FAIL basic_resp: got dok=%b%b rdata=%h expected %b%b 02800c0c",
               inst_data_ok, data_data_ok, inst_rdata, ~e, e);
    end
    cyc();
    idle_inputs();
  endtask
  task automatic test_lock;
`ifdef ARB_RR_EN
    w = 0;
`else
    w = 1;
`endif
    cyc();
    inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      mem_addr_ok = (k == 3);
      #1;
      checks++;
      if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !==
          {1'b1, (w ? 32'h2000 : 32'h1000), ~w & (k == 3), w & (k == 3)}) begin
        errors++;
        $display("FAIL lock_hold[%0d]: got req=%b addr=%h aok=%b%b", k, mem_req, mem_addr,
                 inst_addr_ok, data_addr_ok);
      end
      cyc();
    end
    sb.push_back(w);
    if (w) data_req = 0; else inst_req = 0;
    mem_addr_ok = 1;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== {w, ~w}) begin
      errors++;
      $display("FAIL lock_loser: got aok=%b%b expected %b%b", inst_addr_ok, data_addr_ok, w, ~w);
    end
    sb.push_back(~w);
    cyc();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      mem_data_ok = 1; mem_rdata = 32'hA000_0000 + k;
      #1;
      pop_exp(e);
      checks++;
      if ({inst_data_ok, data_data_ok, (e ? data_rdata : inst_rdata)} !== {~e, e, 32'hA000_0000 + k}) begin
        errors++;
        $display("FAIL lock_resp[%0d]: got dok=%b%b expected %b%b", k, inst_data_ok, data_data_ok, ~e, e);
      end
      cyc();
    end
    idle_inputs();
  endtask
  task automatic test_full;
    cyc();
    inst_req = 1; inst_addr = 32'h10; mem_addr_ok = 1;
    #1;
    if (inst_addr_ok) sb.push_back(0);
    cyc();
    inst_req = 0; data_req = 1; data_addr = 32'h20;
    #1;
    if (data_addr_ok) sb.push_back(1);
    checks++;
    if (sb.size() != 2) begin errors++; $display("FAIL full_fill: got %0d accepts expected 2", sb.size()); end
    cyc();
    data_req = 0; inst_req = 1; inst_addr = 32'h30;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin
      errors++;
      $display("FAIL full_block: got req=%b aok=%b%b expected 000", mem_req, inst_addr_ok, data_addr_ok);
    end
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h1111_1111;
    #1;
    pop_exp(e);
    checks++;
    if ({inst_data_ok, data_data_ok, mem_req, inst_addr_ok} !== {~e, e, 2'b00}) begin
      errors++;
      $display("FAIL full_pop: got dok=%b%b req=%b aok=%b expected %b%b00", inst_data_ok, data_data_ok,
               mem_req, inst_addr_ok, ~e, e);
    end
    cyc();
    mem_data_ok = 0;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, mem_addr} !== {2'b11, 32'h30}) begin
      errors++;
      $display("FAIL full_retry: got req=%b aok=%b addr=%h expected 11 30", mem_req, inst_addr_ok, mem_addr);
    end
    sb.push_back(0);
    cyc();
    inst_req = 0; mem_data_ok = 1; mem_rdata = 32'h2222_2222;
    #1;
    pop_exp(e);
    checks++;
    if ({inst_data_ok, data_data_ok, data_rdata} !== {~e, e, 32'h2222_2222}) begin
      errors++;
      $display("FAIL drain_data: got dok=%b%b expected %b%b", inst_data_ok, data_data_ok, ~e, e);
    end
    cyc();
    data_req = 1; data_addr = 32'h40; mem_data_ok = 1; mem_rdata = 32'h3333_3333;
    #1;
    pop_exp(e);
    checks++;
    if ({inst_data_ok, data_data_ok, data_addr_ok, inst_addr_ok} !== {~e, e, 2'b10}) begin
      errors++;
      $display("FAIL push_pop: got dok=%b%b aok(d,i)=%b%b expected %b%b10", inst_data_ok, data_data_ok,
               data_addr_ok, inst_addr_ok, ~e, e);
    end
    sb.push_back(1);
    cyc();
    data_req = 0; mem_data_ok = 1; mem_rdata = 32'h4444_4444;
    #1;
    pop_exp(e);
    checks++;
    if ({inst_data_ok, data_data_ok, data_rdata} !== {~e, e, 32'h4444_4444}) begin
      errors++;
      $display("FAIL push_pop_tail: got dok=%b%b expected %b%b", inst_data_ok, data_data_ok, ~e, e);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", err); end
  endtask
  task automatic test_spurious;
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h5555_5555;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok, err} !== 3'b000) begin
      errors++;
      $display("FAIL spur_dok: got dok=%b%b err=%b expected 000", inst_data_ok, data_data_ok, err);
    end
    cyc();
    mem_data_ok = 0;
    cyc();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b expected 1", err); end
    reset = 1;
    cyc();
    reset = 0;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b expected 0", err); end
  endtask
  task automatic test_reset_in_lock;
    cyc();
    inst_req = 1; inst_addr = 32'h50; mem_addr_ok = 1;
    cyc();
    inst_req = 0; data_req = 1; data_addr = 32'h60; mem_addr_ok = 0;
    cyc();
    reset = 1;
    cyc();
    reset = 0; data_req = 0;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_addr, err} !== 38'd0) begin
      errors++;
      $display("FAIL lockrst_out: got req=%b addr=%h err=%b expected 0", mem_req, mem_addr, err);
    end
    cyc();
    mem_data_ok = 1;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errors++;
      $display("FAIL lockrst_dok: got %b%b expected 00", inst_data_ok, data_data_ok);
    end
    cyc();
    mem_data_ok = 0;
    inst_req = 1; inst_addr = 32'h70; mem_addr_ok = 1;
    #1;
    checks++;
    if ({err, inst_addr_ok, mem_addr} !== {2'b11, 32'h70}) begin
      errors++;
      $display("FAIL lockrst_idle: got err=%b aok=%b addr=%h expected 11 70", err, inst_addr_ok, mem_addr);
    end
    cyc();
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    do_reset();
    test_lock();
    do_reset();
    test_full();
    do_reset();
    test_spurious();
    do_reset();
    test_reset_in_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
